hdb3_tx_ctrl: RTL

HDB3_TX_CTRL -- requirements
Module: hdb3_tx_ctrl

---
 rtl/hdb3_tx_ctrl_pkg.sv | 31 +++
 rtl/hdb3_dly_line.sv | 26 ++
 rtl/hdb3_tx_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/hdb3_tx_ctrl_pkg.sv
// Shared HDB3 definitions: line-symbol encodings, transmit FSM states and
// small helpers used by the encoder stages.
package hdb3_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FILL  = 2'd2,
    ST_FLUSH = 2'd3
  } tx_state_e;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_B    = 2'b10;
  localparam logic [1:0] SYM_V    = 2'b11;

  localparam int BIT_W   = 3;
  localparam int FLUSH_W = 4;

  localparam logic [BIT_W-1:0] BIT_LAST = 3'd7;

  // Flush counter runs lat-1 down to 0, giving exactly lat drain bits.
  function automatic logic [FLUSH_W-1:0] flush_init(input int lat);
    return FLUSH_W'(lat - 1);
  endfunction

  function automatic logic [1:0] gate_code(input logic vld, input logic [1:0] code);
    return vld ? code : SYM_ZERO;
  endfunction

endpackage

// File: rtl/hdb3_dly_line.sv
// Fixed-depth register delay line; used to align valid flags with the
// latency of downstream encoder stages.
module hdb3_dly_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] tap_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) tap_q[i] <= '0;
    end else begin
      tap_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) tap_q[i] <= tap_q[i-1];
    end
  end

  assign q_o = tap_q[DEPTH-1];

endmodule

// File: rtl/hdb3_tx_ctrl.sv
// HDB3 transmit controller: serialises payload bytes MSB first, pads with
// zero fill bytes on underrun, drains the encoder on stop, realigns codes.
module hdb3_tx_ctrl
  import hdb3_tx_ctrl_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_bit,
  output logic       o_bit_valid,
  input  logic [1:0] i_code,
  output logic [1:0] o_code,
  output logic       o_code_valid,
  output logic       o_busy,
  output logic       o_underrun
);

  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("hdb3_tx_ctrl: LAT must be within 1..15");
  end

  localparam logic [FLUSH_W-1:0] FLUSH_INIT = flush_init(LAT);

  tx_state_e          state_q, state_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [FLUSH_W-1:0] flcnt_q, flcnt_d;
  logic               underrun_q, underrun_d;
  logic               live_q;
  logic               byte_ready;
  logic               byte_end;
  logic               accept;

  assign byte_end = (bitcnt_q == '0);
  assign accept   = byte_ready & i_byte_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // live_q holds ready low until the first clock after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      flcnt_q    <= '0;
      underrun_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      flcnt_q    <= flcnt_d;
      underrun_q <= underrun_d;
      live_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    flcnt_d    = flcnt_q;
    underrun_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d  = i_byte;
          bitcnt_d = BIT_LAST;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT, ST_FILL: begin
        if (byte_end) begin
          bitcnt_d = BIT_LAST;
          if (accept) begin
            shreg_d = i_byte;
            state_d = ST_SHIFT;
          end else if (i_en) begin
            shreg_d    = '0;
            state_d    = ST_FILL;
            underrun_d = 1'b1;
          end else begin
            shreg_d = '0;
            flcnt_d = FLUSH_INIT;
            state_d = ST_FLUSH;
          end
        end else begin
          shreg_d  = {shreg_q[6:0], 1'b0};
          bitcnt_d = bitcnt_q - 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flcnt_q == '0) state_d = ST_IDLE;
        else               flcnt_d = flcnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready mid-stream only on the last bit of a byte, so the next byte
  // follows with no bubble.
  always_comb begin
    o_bit       = 1'b0;
    o_bit_valid = 1'b0;
    byte_ready  = 1'b0;
    unique case (state_q)
      ST_IDLE: byte_ready = i_en & live_q;
      ST_SHIFT: begin
        o_bit       = shreg_q[7];
        o_bit_valid = 1'b1;
        byte_ready  = byte_end & i_en;
      end
      ST_FILL: begin
        o_bit_valid = 1'b1;
        byte_ready  = byte_end & i_en;
      end
      ST_FLUSH: o_bit_valid = 1'b1;
      default: begin
        o_bit       = 1'b0;
        o_bit_valid = 1'b0;
        byte_ready  = 1'b0;
      end
    endcase
  end

  assign o_byte_ready = byte_ready;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_underrun   = underrun_q;

  hdb3_dly_line #(
    .WIDTH (1),
    .DEPTH (LAT)
  ) u_vld_dly (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .d_i    (o_bit_valid),
    .q_o    (o_code_valid)
  );

  assign o_code = gate_code(o_code_valid, i_code);

endmodule
